// File: rtl/line_cache.sv
// rtl/line_cache.sv - set-associative read cache with line refill engine and write-through snoop
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        core request handshake, req_addr byte address
//   resp_valid/resp_data       one-cycle response strobe and word (0 when idle)
//   mem_req_valid/ready/addr   refill beat request towards the memory bus
//   mem_resp_valid/data        refill beat return
//   update/update_addr/data    snooped store, overwrites a cached word in place
//   flush                      invalidate every line and reset replacement pointers
//   hit_count/miss_count       saturating lookup statistics (only with CACHE_STATS_EN)
//
// Optional feature macro: CACHE_STATS_EN

module line_cache #(
  parameter int XLEN        = 32,
  parameter int BYTE_OFFSET = 2,
  parameter int WORD_WIDTH  = 2,
  parameter int SET_WIDTH   = 4,
  parameter int N_WIDTH     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            update,
  input  logic [XLEN-1:0] update_addr,
  input  logic [XLEN-1:0] update_data,
  input  logic            flush
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int WORDS     = 1 << WORD_WIDTH;
  localparam int SETS      = 1 << SET_WIDTH;
  localparam int WAYS      = 1 << N_WIDTH;
  localparam int TAG_WIDTH = XLEN - BYTE_OFFSET - WORD_WIDTH - SET_WIDTH;
  localparam int SET_LSB   = BYTE_OFFSET + WORD_WIDTH;
  localparam int TAG_LSB   = SET_LSB + SET_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP} state_t;

  state_t                  state;
  logic [XLEN-1:0]         addr_q;
  logic [WORD_WIDTH-1:0]   beat;
  logic [N_WIDTH-1:0]      victim;
  logic                    flushed_q;

  logic [WAYS-1:0]         valid   [SETS];
  logic [N_WIDTH-1:0]      rr      [SETS];
  logic [TAG_WIDTH-1:0]    tag_mem [WAYS][SETS];
  logic [XLEN-1:0]         data_mem[WAYS][SETS][WORDS];

  // Fields of the request currently being served
  logic [TAG_WIDTH-1:0]    cur_tag;
  logic [SET_WIDTH-1:0]    cur_set;
  logic [WORD_WIDTH-1:0]   cur_word;
  assign cur_tag  = addr_q[XLEN-1:TAG_LSB];
  assign cur_set  = addr_q[TAG_LSB-1:SET_LSB];
  assign cur_word = addr_q[SET_LSB-1:BYTE_OFFSET];

  // Fields of the snooped store
  logic [TAG_WIDTH-1:0]    upd_tag;
  logic [SET_WIDTH-1:0]    upd_set;
  logic [WORD_WIDTH-1:0]   upd_word;
  assign upd_tag  = update_addr[XLEN-1:TAG_LSB];
  assign upd_set  = update_addr[TAG_LSB-1:SET_LSB];
  assign upd_word = update_addr[SET_LSB-1:BYTE_OFFSET];

  // Byte-in-word bits carry no information for a word cache
  logic unused_ok;
  assign unused_ok = ^{addr_q[BYTE_OFFSET-1:0], update_addr[BYTE_OFFSET-1:0]};

  logic                    hit;
  logic [N_WIDTH-1:0]      hit_way;
  logic                    upd_hit;
  logic [N_WIDTH-1:0]      upd_way;
  logic                    refill_upd;
  logic                    last_beat;
  logic                    beat_done;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[cur_set][w] && tag_mem[w][cur_set] == cur_tag) begin
        hit     = 1'b1;
        hit_way = N_WIDTH'(w);
      end
    end
  end

  always_comb begin
    upd_hit = 1'b0;
    upd_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[upd_set][w] && tag_mem[w][upd_set] == upd_tag) begin
        upd_hit = 1'b1;
        upd_way = N_WIDTH'(w);
      end
    end
  end

  // A store to the line being refilled only lands on words already written;
  // later words will be fetched from memory, which already holds the new value.
  assign refill_upd = update && (state == MEM_REQ || state == MEM_WAIT) &&
                      upd_tag == cur_tag && upd_set == cur_set && upd_word < beat;
  assign last_beat  = (beat == WORD_WIDTH'(WORDS - 1));
  assign beat_done  = (state == MEM_WAIT) && mem_resp_valid;

  // Responses read the arrays before this cycle's writes, so a same-cycle
  // snoop to the word being returned shows up only on the next access.
  always_comb begin
    resp_valid = 1'b0;
    resp_data  = '0;
    if (state == LOOKUP && hit) begin
      resp_valid = 1'b1;
      resp_data  = data_mem[hit_way][cur_set][cur_word];
    end else if (state == RESP) begin
      resp_valid = 1'b1;
      resp_data  = data_mem[victim][cur_set][cur_word];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      addr_q        <= '0;
      beat          <= '0;
      victim        <= '0;
      flushed_q     <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            // The victim is dropped now so its half-overwritten data can
            // never be matched under its old tag.
            beat                     <= '0;
            victim                   <= rr[cur_set];
            valid[cur_set][rr[cur_set]] <= 1'b0;
            flushed_q                <= flush;
            mem_req_valid            <= 1'b1;
            mem_req_addr             <= {cur_tag, cur_set, {WORD_WIDTH{1'b0}}, {BYTE_OFFSET{1'b0}}};
            state                    <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_resp_valid) begin
            if (last_beat) begin
              if (!flushed_q) begin
                valid[cur_set][victim] <= 1'b1;
                rr[cur_set]            <= rr[cur_set] + N_WIDTH'(1);
              end
              state <= RESP;
            end else begin
              beat          <= beat + WORD_WIDTH'(1);
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {cur_tag, cur_set, beat + WORD_WIDTH'(1), {BYTE_OFFSET{1'b0}}};
              state         <= MEM_REQ;
            end
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Flush overrides any install happening in the same cycle
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          rr[s]    <= '0;
        end
      end
    end
  end

  // Tag and data storage carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (beat_done && last_beat) begin
      tag_mem[victim][cur_set] <= cur_tag;
    end
    if (update && upd_hit) begin
      data_mem[upd_way][upd_set][upd_word] <= update_data;
    end
    if (refill_upd) begin
      data_mem[victim][cur_set][upd_word] <= update_data;
    end
    if (beat_done) begin
      data_mem[victim][cur_set][beat] <= mem_resp_data;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/line_cache.md
# line_cache

Parametrised set-associative read cache with multi-word lines, an autonomous refill engine and a write-through snoop port. It sits between a core fetch/load port and the memory bus. Hits are served one cycle after request acceptance. Misses fetch a full line beat-by-beat, install it with round-robin replacement, then respond.

## Interface
- XLEN, 32, data/address width
- BYTE_OFFSET, 2, byte-in-word address bits
- WORD_WIDTH, 2, log2 words per line (WORDS = 2**WORD_WIDTH)
- SET_WIDTH, 4, log2 sets
- N_WIDTH, 1, log2 ways; TAG_WIDTH = XLEN-BYTE_OFFSET-WORD_WIDTH-SET_WIDTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in/out  1  core request handshake
- req_addr  in  XLEN  byte address, low BYTE_OFFSET bits ignored
- resp_valid  out  1  one-cycle response strobe (no back-pressure)
- resp_data  out  XLEN  requested word, 0 when resp_valid low
- mem_req_valid / mem_req_ready  out/in  1  refill beat request handshake
- mem_req_addr  out  XLEN  word-aligned beat address
- mem_resp_valid  in  1  refill beat data strobe
- mem_resp_data  in  XLEN  refill beat data
- update  in  1  write-through snoop strobe
- update_addr / update_data  in  XLEN  snooped store address/data
- flush  in  1  invalidate all lines

## Operation
- FSM states: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP.
- IDLE: req_ready=1; on req_valid, latch address -> LOOKUP.
- LOOKUP: compare tag against all ways of set. Hit: resp_valid=1, data from hit way -> IDLE. Miss: beat counter=0, latch victim way = rr[set] -> MEM_REQ.
- MEM_REQ: mem_req_valid=1, mem_req_addr = {tag,set,beat,BYTE_OFFSET zeros}; on mem_req_ready -> MEM_WAIT. mem_req_valid held until handshake, address stable.
- MEM_WAIT: on mem_resp_valid write word[beat] of victim; if beat==WORDS-1 -> install (valid=1, tag written, rr[set]+=1 wrapping modulo N) -> RESP, else beat+=1 -> MEM_REQ. One beat outstanding at a time.
- RESP: resp_valid=1 with requested word from installed line -> IDLE.
- Snoop: update on a valid matching line overwrites that word; misses never allocate. Update to the line under refill: overwrite if word index < beat (already filled), else ignore.
- Update and hit to same word in same cycle: resp_data returns old value; new value visible next access.
- flush: clears all valid bits and rr pointers at next edge. If asserted during refill, refill completes and response is returned, but line is not marked valid. flush with simultaneous install: flush wins.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all valid=0, rr=0, beat=0; req_ready=0 while rst_n low, resp_valid=0, resp_data=0, mem_req_valid=0, mem_req_addr=0. Data/tag arrays not reset.
- Hit latency: accept at edge k, resp_valid high in cycle k..k+1.
- Miss latency: 1 + WORDS×(req handshake + resp wait) + 1 cycles; minimum 2+2×WORDS with zero-wait memory.
- req_ready low in all states except IDLE; next request accepted in cycle after resp_valid.
- Reset mid-refill abandons the transaction; memory responses after reset ignored (mem_resp_valid outside MEM_WAIT ignored).

## Configuration
- CACHE_STATS_EN: when defined, adds outputs hit_count and miss_count (32 bits each), incremented in LOOKUP on hit/miss, saturating at all-ones, cleared only by reset. Undefined: ports and counters absent, behaviour otherwise identical.

## Test plan
- Reset then read 0x100 with memory returning 0xA0+beat, zero-wait -> 4 mem beats at 0x100,0x104,0x108,0x10C; resp_data=0xA0; read 0x108 -> hit next cycle, resp_data=0xA2.
- Three distinct tags mapping to set 0 (N=2) -> third miss evicts way 0; re-read first tag misses, second still hits.
- update 0x104=0xDEAD after fill -> read 0x104 returns 0xDEAD; update to uncached 0x2000 -> read 0x2000 misses.
- flush after fills -> all previously cached addresses miss; flush during MEM_WAIT -> response delivered, same address misses next.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable; rst_n pulsed low mid-refill -> mem_req_valid 0 immediately, FSM IDLE.
- With CACHE_STATS_EN: 1 miss then 3 hits -> miss_count=1, hit_count=3.
